// File: rtl/logic_lab_pkg.sv
// logic_lab_pkg: shared scan states and sizing helpers for the truth-table scanner
package logic_lab_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} scan_state_t;

    function automatic int n_vec(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// settle_counter: loadable down-counter timing how long each vector is held
module settle_counter #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // load to SETTLE_CYCLES-1 so the count reaches zero after exactly SETTLE_CYCLES enabled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= CW'(SETTLE_CYCLES - 1);
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end

    assign zero = cnt == '0;

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks a combinational block through every input vector and checks its truth table
module truth_table_scanner
    import logic_lab_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4,
    localparam int N_VEC        = n_vec(N_IN),
    localparam int CNT_W        = $clog2(N_VEC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_VEC-1:0] expected,
    output logic [N_IN-1:0]  vec_out,
    input  logic             f_in,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] table_out,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             match
);

    scan_state_t      state;
    logic [N_IN-1:0]  idx;
    logic [N_VEC-1:0] exp_q;
    logic [N_VEC-1:0] work_table;
    logic [N_VEC-1:0] table_next;
    logic [CNT_W-1:0] work_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             last;
    logic             settle_zero;
    logic             cnt_load;

    assign last     = &idx;
    assign cnt_load = (state == IDLE && start) || (state == SAMPLE && !abort && !last);

    settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
        .clk  (clk),
        .rst_n(rst_n),
        .load (cnt_load),
        .en   (state == SETTLE),
        .zero (settle_zero)
    );

    // working table and count including the bit being sampled this cycle, so the commit sees it
    always_comb begin
        table_next      = work_table;
        table_next[idx] = f_in;
        cnt_next        = work_cnt + CNT_W'(f_in != exp_q[idx]);
    end

    // scan sequencer; abort is checked before the last-vector commit so it always wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            exp_q        <= '0;
            work_table   <= '0;
            work_cnt     <= '0;
            vec_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            match        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    exp_q      <= expected;
                    idx        <= '0;
                    work_table <= '0;
                    work_cnt   <= '0;
                    vec_out    <= '0;
                    busy       <= 1'b1;
                    state      <= SETTLE;
                end
                SETTLE: if (abort) begin
                    busy    <= 1'b0;
                    vec_out <= '0;
                    state   <= IDLE;
                end else if (settle_zero) begin
                    state <= SAMPLE;
                end
                SAMPLE: if (abort) begin
                    busy    <= 1'b0;
                    vec_out <= '0;
                    state   <= IDLE;
                end else begin
                    work_table <= table_next;
                    work_cnt   <= cnt_next;
                    if (last) begin
                        table_out    <= table_next;
                        mismatch_cnt <= cnt_next;
                        match        <= cnt_next == '0;
                        busy         <= 1'b0;
                        vec_out      <= '0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else begin
                        idx     <= idx + 1'b1;
                        vec_out <= idx + 1'b1;
                        state   <= SETTLE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: scoreboard bench scanning a majority function with default and minimal settle times
module tb_truth_table_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [7:0] exp_a = 8'h00, exp_b = 8'h00;
    logic [2:0] vec_a, vec_b;
    logic       f_a, f_b, busy_a, busy_b, done_a, done_b, match_a, match_b;
    logic [7:0] tbl_a, tbl_b;
    logic [3:0] cnt_a, cnt_b;
    int         cyc = 0, sa = 0, sb = 0, vecs = 0, misc = 0;

    typedef struct {
        logic [7:0] tbl;
        int         cnt;
        logic       m;
        int         lat;
    } exp_t;

    exp_t qa[$], qb[$];

    assign f_a = (vec_a[2] & vec_a[1]) | (vec_a[1] & vec_a[0]) | (vec_a[2] & vec_a[0]);
    assign f_b = (vec_b[2] & vec_b[1]) | (vec_b[1] & vec_b[0]) | (vec_b[2] & vec_b[0]);

    truth_table_scanner #(.N_IN(3), .SETTLE_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .expected(exp_a),
        .vec_out(vec_a), .f_in(f_a), .busy(busy_a), .done(done_a),
        .table_out(tbl_a), .mismatch_cnt(cnt_a), .match(match_a)
    );

    truth_table_scanner #(.N_IN(3), .SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .expected(exp_b),
        .vec_out(vec_b), .f_in(f_b), .busy(busy_b), .done(done_b),
        .table_out(tbl_b), .mismatch_cnt(cnt_b), .match(match_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vecs++;
        if (act !== want) begin
            misc++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic start_scan_a(input logic [7:0] ex, input logic [7:0] tbl, input int cnt, input logic m, input bit push);
        exp_t e;
        @(negedge clk);
        e.tbl = tbl; e.cnt = cnt; e.m = m; e.lat = 41;
        if (push) qa.push_back(e);
        exp_a = ex; start_a = 1'b1; sa = cyc;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic start_scan_b(input logic [7:0] ex, input logic [7:0] tbl, input int cnt, input logic m);
        exp_t e;
        @(negedge clk);
        e.tbl = tbl; e.cnt = cnt; e.m = m; e.lat = 17;
        qb.push_back(e);
        exp_b = ex; start_b = 1'b1; sb = cyc;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic to_a(input int k);
        while (cyc - sa < k) @(negedge clk);
    endtask

    task automatic to_b(input int k);
        while (cyc - sb < k) @(negedge clk);
    endtask

    // monitor: every done pulse pops the oldest expected result for that scanner
    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            if (qa.size() == 0) chk("unexpected done A", 1, 0);
            else begin
                e = qa.pop_front();
                chk("table_out A", tbl_a, e.tbl);
                chk("mismatch_cnt A", cnt_a, e.cnt);
                chk("match A", match_a, e.m);
                chk("done latency A", cyc - sa, e.lat);
            end
        end
        if (done_b) begin
            if (qb.size() == 0) chk("unexpected done B", 1, 0);
            else begin
                e = qb.pop_front();
                chk("table_out B", tbl_b, e.tbl);
                chk("mismatch_cnt B", cnt_b, e.cnt);
                chk("match B", match_b, e.m);
                chk("done latency B", cyc - sb, e.lat);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset vec_out", vec_a, 0);
        chk("reset busy", busy_a, 0);
        chk("reset done", done_a, 0);
        chk("reset table_out", tbl_a, 0);
        chk("reset mismatch_cnt", cnt_a, 0);
        chk("reset match", match_a, 0);
        rst_n = 1'b1;
        start_scan_a(8'hE8, 8'hE8, 0, 1'b1, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            to_a(k);
            chk("vec_out step", vec_a, (k - 1) / 5);
            chk("busy scanning", busy_a, 1);
        end
        to_a(43);
        chk("idle busy", busy_a, 0);
        chk("idle vec_out", vec_a, 0);
        start_scan_a(8'hE9, 8'hE8, 1, 1'b0, 1'b1);
        to_a(43);
        start_scan_a(8'h17, 8'hE8, 8, 1'b0, 1'b1);
        to_a(43);
        start_scan_a(8'hE8, 8'hE8, 0, 1'b1, 1'b1);
        to_a(10);
        exp_a = 8'h00; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        to_a(20);
        exp_a = 8'h00; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        to_a(43);
        chk("start not queued", busy_a, 0);
        start_scan_a(8'hE9, 8'h00, 0, 1'b0, 1'b0);
        to_a(15);
        abort_a = 1'b1;
        to_a(16);
        abort_a = 1'b0;
        chk("abort busy", busy_a, 0);
        chk("abort vec_out", vec_a, 0);
        chk("abort keeps table", tbl_a, 8'hE8);
        chk("abort keeps cnt", cnt_a, 0);
        chk("abort keeps match", match_a, 1);
        to_a(45);
        start_scan_a(8'hE9, 8'h00, 0, 1'b0, 1'b0);
        to_a(40);
        abort_a = 1'b1;
        to_a(41);
        abort_a = 1'b0;
        chk("last abort busy", busy_a, 0);
        chk("last abort table", tbl_a, 8'hE8);
        chk("last abort cnt", cnt_a, 0);
        chk("last abort match", match_a, 1);
        to_a(45);
        start_scan_a(8'hE8, 8'h00, 0, 1'b0, 1'b0);
        to_a(20);
        rst_n = 1'b0;
        #1;
        chk("async rst vec_out", vec_a, 0);
        chk("async rst busy", busy_a, 0);
        chk("async rst table_out", tbl_a, 0);
        chk("async rst mismatch_cnt", cnt_a, 0);
        chk("async rst match", match_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_scan_a(8'hE8, 8'hE8, 0, 1'b1, 1'b1);
        to_a(43);
        start_scan_b(8'hE8, 8'hE8, 0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            to_b(k);
            chk("vec_out step B", vec_b, (k - 1) / 2);
        end
        to_b(17);
        start_scan_b(8'hE9, 8'hE8, 1, 1'b0);
        to_b(20);
        chk("A results pending", qa.size(), 0);
        chk("B results pending", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
        $finish;
    end

endmodule
